// File: rtl/encrypter_output_arbiter.sv
// Round-robin collector that serialises finished encrypter blocks, MSB nibble first, onto a 4-bit QSPI stream.
// Optional trailing XOR checksum nibble per block when OUT_ARB_CHECKSUM_EN is defined.
module encrypter_output_arbiter #(
    parameter int NUM_ENCRYPTERS  = 4,
    parameter int ENCRYPTER_WIDTH = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_data,
    input  logic [NUM_ENCRYPTERS-1:0]                 enc_valid,
    output logic [NUM_ENCRYPTERS-1:0]                 enc_ack,
    input  logic                                      dispatch,
    output logic [3:0]                                qspi_out_data,
    output logic                                      qspi_out_valid,
    input  logic                                      qspi_out_ready,
    output logic [$clog2(NUM_ENCRYPTERS):0]           outstanding,
    output logic [$clog2(NUM_ENCRYPTERS)-1:0]         rr_ptr,
    output logic                                      overflow
);
    localparam int NIBBLES = ENCRYPTER_WIDTH / 4;
    localparam int PTR_W   = $clog2(NUM_ENCRYPTERS);
    localparam int CNT_W   = PTR_W + 1;
    localparam int NIB_W   = $clog2(NIBBLES + 1);
`ifdef OUT_ARB_CHECKSUM_EN
    localparam int LAST_NIB = NIBBLES;
`else
    localparam int LAST_NIB = NIBBLES - 1;
`endif
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENCRYPTERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [ENCRYPTER_WIDTH-1:0]   shift_q, shift_d;
    logic [NIB_W-1:0]             nib_cnt_q, nib_cnt_d;
    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]             outstanding_q, outstanding_d;
    logic                         overflow_q, overflow_d;
    logic [NUM_ENCRYPTERS-1:0]    enc_ack_q, enc_ack_d;
    logic                         out_valid_q, out_valid_d;
    logic [3:0]                   out_data_q, out_data_d;
`ifdef OUT_ARB_CHECKSUM_EN
    logic [3:0]                   csum_q, csum_d;
`endif
    logic                         hs_s;
    logic                         done_s;
    logic                         accept_s;

    // Next-state logic: FSM, shifter, pointer, outstanding bookkeeping and registered outputs.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        nib_cnt_d     = nib_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        overflow_d    = overflow_q;
        enc_ack_d     = '0;
`ifdef OUT_ARB_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        hs_s     = (state_q == ST_SEND) && qspi_out_ready;
        done_s   = hs_s && (nib_cnt_q == NIB_W'(LAST_NIB));
        accept_s = dispatch && (outstanding_q != FULL_CNT);

        if (dispatch && (outstanding_q == FULL_CNT)) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        // Completion never coincides with zero outstanding, so no underflow guard is needed.
        outstanding_d = outstanding_q + CNT_W'(accept_s) - CNT_W'(done_s);

        case (state_q)
            ST_IDLE: begin
                if (outstanding_q != {CNT_W{1'b0}}) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (enc_valid[rr_ptr_q]) begin
                    shift_d             = enc_data[rr_ptr_q*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
                    enc_ack_d[rr_ptr_q] = 1'b1;
                    nib_cnt_d           = {NIB_W{1'b0}};
`ifdef OUT_ARB_CHECKSUM_EN
                    csum_d              = 4'h0;
`endif
                    state_d             = ST_SEND;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (hs_s) begin
                    shift_d   = shift_q << 4;
                    nib_cnt_d = nib_cnt_q + NIB_W'(1);
`ifdef OUT_ARB_CHECKSUM_EN
                    csum_d    = csum_q ^ shift_q[ENCRYPTER_WIDTH-1 -: 4];
`endif
                    if (done_s) begin
                        rr_ptr_d = rr_ptr_q + PTR_W'(1);
                        // Net count decides, so IDLE is only entered with nothing outstanding.
                        if (outstanding_d != {CNT_W{1'b0}}) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_SEND);
        if (out_valid_d) begin
`ifdef OUT_ARB_CHECKSUM_EN
            if (nib_cnt_d == NIB_W'(NIBBLES)) begin
                out_data_d = csum_d;
            end else begin
                out_data_d = shift_d[ENCRYPTER_WIDTH-1 -: 4];
            end
`else
            out_data_d = shift_d[ENCRYPTER_WIDTH-1 -: 4];
`endif
        end else begin
            out_data_d = 4'h0;
        end
    end

    // State and output registers with synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            nib_cnt_q     <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
            enc_ack_q     <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 4'h0;
`ifdef OUT_ARB_CHECKSUM_EN
            csum_q        <= 4'h0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            nib_cnt_q     <= nib_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            overflow_q    <= overflow_d;
            enc_ack_q     <= enc_ack_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
`ifdef OUT_ARB_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign enc_ack        = enc_ack_q;
    assign qspi_out_data  = out_data_q;
    assign qspi_out_valid = out_valid_q;
    assign outstanding    = outstanding_q;
    assign rr_ptr         = rr_ptr_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_encrypter_output_arbiter.sv
// Bench for encrypter_output_arbiter: queue-based reference model compared every cycle, plus directed literal checks.
module tb_encrypter_output_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int NIB = W / 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] enc_data;
    logic [N-1:0]   enc_valid;
    logic [N-1:0]   enc_ack;
    logic           dispatch;
    logic [3:0]     qspi_out_data;
    logic           qspi_out_valid;
    logic           qspi_out_ready;
    logic [2:0]     outstanding;
    logic [1:0]     rr_ptr;
    logic           overflow;

    encrypter_output_arbiter #(.NUM_ENCRYPTERS(N), .ENCRYPTER_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enc_data(enc_data), .enc_valid(enc_valid),
        .enc_ack(enc_ack), .dispatch(dispatch), .qspi_out_data(qspi_out_data),
        .qspi_out_valid(qspi_out_valid), .qspi_out_ready(qspi_out_ready),
        .outstanding(outstanding), .rr_ptr(rr_ptr), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int ack_cyc [N];
    int ack_pulses = 0;
    logic [3:0] nib_log [$];

    // Reference model: pending count, pointer, queue of nibbles still to leave.
    int         m_out = 0;
    int         m_ptr = 0;
    bit         m_ovf = 1'b0;
    bit         m_wait = 1'b0;
    logic [3:0] m_q [$];
    logic [N-1:0] m_ack = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic model_step();
        bit sending, done, inc;
        logic [W-1:0] blk;
        logic [3:0] x;
        if (reset) begin
            m_out = 0; m_ptr = 0; m_ovf = 1'b0; m_wait = 1'b0; m_q.delete(); m_ack = '0;
        end else begin
            sending = (m_q.size() != 0);
            done    = sending && qspi_out_ready && (m_q.size() == 1);
            if (sending && qspi_out_ready) void'(m_q.pop_front());
            inc = dispatch && (m_out < N);
            if (dispatch && m_out == N) m_ovf = 1'b1;
            m_ack = '0;
            if (m_wait && enc_valid[m_ptr]) begin
                blk = enc_data[m_ptr*W +: W];
                x = 4'h0;
                for (int k = NIB - 1; k >= 0; k--) begin
                    m_q.push_back(blk[k*4 +: 4]);
                    x = x ^ blk[k*4 +: 4];
                end
`ifdef OUT_ARB_CHECKSUM_EN
                m_q.push_back(x);
`endif
                m_ack[m_ptr] = 1'b1;
                m_wait = 1'b0;
            end else if (!sending && !m_wait && m_out > 0) begin
                m_wait = 1'b1;
            end
            if (done) m_ptr = (m_ptr + 1) % N;
            m_out = m_out + int'(inc) - int'(done);
            if (done) m_wait = (m_out > 0);
        end
    endtask

    // Model advances on each rising edge; outputs are compared on the falling edge.
    initial begin
        for (int i = 0; i < N; i++) ack_cyc[i] = -1;
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
            if (chk_en) begin
                check("valid", qspi_out_valid, m_q.size() != 0);
                check("data", qspi_out_data, (m_q.size() != 0) ? m_q[0] : 4'h0);
                check("ack", enc_ack, m_ack);
                check("outstanding", outstanding, m_out);
                check("rr_ptr", rr_ptr, m_ptr);
                check("overflow", overflow, m_ovf);
                if (qspi_out_valid && qspi_out_ready) nib_log.push_back(qspi_out_data);
                if (enc_ack != '0) ack_pulses++;
                for (int i = 0; i < N; i++) if (enc_ack[i]) ack_cyc[i] = cyc;
            end
        end
    end

    function automatic logic [W-1:0] word_at(input int idx);
        logic [W-1:0] w;
        w = 'x;
        if (idx >= 0 && idx + NIB <= nib_log.size()) begin
            for (int k = 0; k < NIB; k++) w[(NIB-1-k)*4 +: 4] = nib_log[idx+k];
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        enc_valid = enc_valid & ~enc_ack;
    endtask

    task automatic do_dispatch(input int n);
        for (int i = 0; i < n; i++) begin
            dispatch = 1'b1;
            tick();
        end
        dispatch = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit toggle_ready);
        int n;
        n = 0;
        while (!(outstanding == 3'd0 && !qspi_out_valid) && n < 300) begin
            if (toggle_ready) qspi_out_ready = ~qspi_out_ready;
            tick();
            n++;
        end
        qspi_out_ready = 1'b1;
        if (n >= 300) check({name, "_timeout"}, n, 0);
    endtask

    task automatic wait_ack(input int idx);
        int n;
        n = 0;
        while (!enc_ack[idx] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ack_timeout", n, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1; dispatch = 1'b1; enc_valid = 4'hF; qspi_out_ready = 1'b1; enc_data = '0;
        tick(); tick();
        chk_en = 1'b1;
        check("rst_valid", qspi_out_valid, 1'b0);
        check("rst_ack", enc_ack, 4'h0);
        check("rst_outstanding", outstanding, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b0; dispatch = 1'b0; enc_valid = 4'h0;
        tick();

        // Single block from encrypter 0.
        base = nib_log.size();
        ack_pulses = 0;
        enc_data[0*W +: W] = 32'hDEADBEEF;
        enc_valid[0] = 1'b1;
        do_dispatch(1);
        wait_idle("single", 1'b0);
        check("single_word", word_at(base), 32'hDEADBEEF);
        check("single_count", nib_log.size() - base, NIB);
        check("single_ack_pulses", ack_pulses, 1);
        check("single_rr_ptr", rr_ptr, 2'd1);
        tick();

        // Encrypter 1 finishes first but encrypter 0 must be served first.
        do_reset();
        base = nib_log.size();
        enc_data[1*W +: W] = 32'h11111111;
        enc_data[0*W +: W] = 32'h22222222;
        enc_valid[1] = 1'b1;
        do_dispatch(2);
        for (int i = 0; i < 5; i++) tick();
        enc_valid[0] = 1'b1;
        wait_idle("order", 1'b0);
        check("order_first", word_at(base), 32'h22222222);
        check("order_second", word_at(base + NIB), 32'h11111111);
        check("order_ack_gap", ack_cyc[1] - ack_cyc[0], NIB + 1);
        check("order_rr_ptr", rr_ptr, 2'd2);

        // Backpressure with toggling ready; four blocks starting at pointer 2 wrap back to 2.
        base = nib_log.size();
        enc_data = {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567};
        enc_valid = 4'hF;
        do_dispatch(4);
        wait_idle("bp", 1'b1);
        check("bp_count", nib_log.size() - base, 4 * NIB);
        check("bp_blk2", word_at(base), 32'hFEDCBA98);
        check("bp_blk3", word_at(base + NIB), 32'h76543210);
        check("bp_blk0", word_at(base + 2*NIB), 32'h01234567);
        check("bp_blk1", word_at(base + 3*NIB), 32'h89ABCDEF);
        check("bp_rr_ptr", rr_ptr, 2'd2);

        // Overflow: five dispatches with nothing finished.
        enc_valid = 4'h0;
        do_dispatch(5);
        check("ovf_outstanding", outstanding, 3'd4);
        check("ovf_flag", overflow, 1'b1);
        tick();
        check("ovf_sticky", overflow, 1'b1);

        // Dispatch coincident with last-nibble handshake leaves the count unchanged.
        do_reset();
        check("ovf_cleared", overflow, 1'b0);
        enc_data[0*W +: W] = 32'hCAFEF00D;
        enc_valid[0] = 1'b1;
        do_dispatch(1);
        wait_ack(0);
        for (int i = 0; i < NIB - 1; i++) tick();
        dispatch = 1'b1;
        tick();
        dispatch = 1'b0;
        check("simul_outstanding", outstanding, 3'd1);
        check("simul_rr_ptr", rr_ptr, 2'd1);
        enc_data[1*W +: W] = 32'h0BADF00D;
        enc_valid[1] = 1'b1;
        wait_idle("simul", 1'b0);

        // Reset in the middle of a block.
        do_reset();
        base = nib_log.size();
        enc_data[0*W +: W] = 32'h12345678;
        enc_valid[0] = 1'b1;
        do_dispatch(1);
        wait_ack(0);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        check("midrst_valid", qspi_out_valid, 1'b0);
        check("midrst_rr_ptr", rr_ptr, 2'd0);
        check("midrst_outstanding", outstanding, 3'd0);
        check("midrst_nibs", {nib_log[base], nib_log[base+1], nib_log[base+2]}, 12'h123);
        reset = 1'b0;
        tick();

        // Full block of the same data, with checksum nibble when enabled.
        base = nib_log.size();
        enc_valid[0] = 1'b1;
        do_dispatch(1);
        wait_idle("full", 1'b0);
        check("full_word", word_at(base), 32'h12345678);
`ifdef OUT_ARB_CHECKSUM_EN
        check("full_count", nib_log.size() - base, NIB + 1);
        check("checksum", nib_log[base + NIB], 4'h8);
`else
        check("full_count", nib_log.size() - base, NIB);
`endif
        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/encrypter_output_arbiter.md
Name: encrypter_output_arbiter

Overview:
- Collects encrypted blocks from the NUM_ENCRYPTERS encrypter instances and serializes them, MSB nibble first, onto a shared 4-bit QSPI output stream.
- Enforces strict round-robin order (encrypter 0,1,..,N-1,0,..), matching the Parallelizer's dispatch order, so ciphertext leaves in plaintext order even when encrypters finish out of order.
- Sits between the encrypter array and the QSPI transmit interface. Tracks outstanding blocks from Parallelizer dispatch pulses.

Parameters:
- NUM_ENCRYPTERS, 4, number of encrypter instances (power of two, >=2).
- ENCRYPTER_WIDTH, 32, block width in bits (multiple of 4). NIBBLES = ENCRYPTER_WIDTH/4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enc_data  in  NUM_ENCRYPTERS*ENCRYPTER_WIDTH  flattened encrypter outputs; encrypter i at [i*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH].
- enc_valid  in  NUM_ENCRYPTERS  encrypter i holds a finished block.
- enc_ack  out  NUM_ENCRYPTERS  one-cycle pulse: block of encrypter i captured.
- dispatch  in  1  one-cycle pulse from Parallelizer: one block dispatched.
- qspi_out_data  out  4  current output nibble.
- qspi_out_valid  out  1  qspi_out_data is valid.
- qspi_out_ready  in  1  downstream accepts the nibble this cycle.
- outstanding  out  clog2(NUM_ENCRYPTERS)+1  blocks dispatched but not yet fully sent.
- rr_ptr  out  clog2(NUM_ENCRYPTERS)  encrypter expected next.
- overflow  out  1  sticky: dispatch received while outstanding==NUM_ENCRYPTERS.

Behaviour:
- Reset: all outputs, state, shift register, nibble counter, rr_ptr, outstanding and overflow go to 0. State goes to IDLE. Reset wins over every other event. A block in flight is dropped and never acked again.
- FSM states: IDLE, WAIT, SEND.
  - IDLE: outstanding==0. Goes to WAIT on the edge after outstanding becomes nonzero.
  - WAIT: at an edge with enc_valid[rr_ptr]=1:
    - capture the slice into the shift register;
    - register enc_ack[rr_ptr]=1 for exactly one cycle;
    - nibble counter=0; go to SEND.
    - enc_valid on other indices is ignored: no ack, no capture.
  - SEND: qspi_out_valid=1, qspi_out_data=shift[W-1:W-4].
    - On valid&&ready: shift left 4 and increment the counter.
    - Without ready: data and valid are held stable.
    - Handshake on the last nibble (counter==NIBBLES-1): rr_ptr=(rr_ptr+1) mod N (wraps N-1 to 0); outstanding decrements; next state is WAIT if the decremented count >0, else IDLE.
- Latency: the edge that samples enc_valid[rr_ptr] is followed by the cycle where enc_ack pulses and the first nibble is valid. With ready held high, a block takes NIBBLES consecutive cycles.
- Back-to-back blocks: the first possible WAIT capture is the edge after the last-nibble handshake. This gives one idle bubble per block (qspi_out_valid=0 in WAIT).
- Encrypters must deassert enc_valid after seeing enc_ack. The arbiter never re-acks the same pointer until it has wrapped.
- outstanding arithmetic:
  - dispatch and last-nibble completion in the same cycle: net unchanged.
  - dispatch at outstanding==N: ignored, overflow set (stays set until reset).
  - completion cannot occur at 0.
- qspi_out_valid is 0 in IDLE and WAIT. qspi_out_data is 0 when not valid.

Optional Feature:
- Macro OUT_ARB_CHECKSUM_EN.
- When defined: after the last data nibble of each block, SEND emits one extra nibble (counter==NIBBLES) equal to the XOR of all NIBBLES data nibbles, with the same ready handshake. Completion bookkeeping occurs on that nibble's handshake.
- When undefined: exactly NIBBLES nibbles per block and no checksum logic.

Test Plan:
- Reset: hold reset 2 cycles with enc_valid=4'hF and dispatch=1 -> all outputs 0, overflow=0, enc_ack=0.
- Single block: 1 dispatch; enc_valid[0]=1, slice 0 = 32'hDEADBEEF; ready=1 -> enc_ack=4'b0001 for one cycle; nibbles D,E,A,D,B,E,E,F on 8 consecutive cycles; then outstanding=0, rr_ptr=1, state IDLE.
- Ordering: 2 dispatches; enc_valid[1] (32'h11111111) asserted 5 cycles before enc_valid[0] (32'h22222222) -> eight 2s sent first, enc_ack[1] only after block 0 completes, then eight 1s; rr_ptr=2.
- Backpressure and wrap: 4 dispatches, ready toggling 1,0,1,0 -> each nibble held stable while ready=0, no nibble lost or duplicated; after block 3, rr_ptr=0.
- Overflow and simultaneity: 5 dispatches with no encrypter valid -> outstanding=4, overflow=1. Dispatch coincident with a last-nibble handshake -> outstanding unchanged.
- Reset mid-send after 3 nibbles of 32'h12345678 -> qspi_out_valid=0 on the next cycle, rr_ptr=0, outstanding=0. With OUT_ARB_CHECKSUM_EN, a full send of 32'h12345678 ends with checksum nibble 4'h8.
